regfile_mp: RTL and testbench

Parametrised multi-port register file for the MIPS datapath, the next generation of the two-read/one-write register file. It provides two write ports with defined priority, a configurable number of read ports with write-to-read bypass, and a per-register pending (scoreboard) bit for hazard detection. Reset clears the array with a sequential sweep (one entry per cycle) so the array maps to distributed RAM. It sits between decode (read/allocate) and writeback (write/clear).

---
 rtl/regfile_mp.sv | 122 ++++++++++++
 tb/tb_regfile_mp.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, NUM_RD bypassed read ports,
// per-register pending bits, and a one-entry-per-cycle clearing sweep after reset.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ready,
    input  logic                       Wen0,
    input  logic [ADDR_W-1:0]          Wa0,
    input  logic [DATA_W-1:0]          Wd0,
    input  logic                       Wen1,
    input  logic [ADDR_W-1:0]          Wa1,
    input  logic [DATA_W-1:0]          Wd1,
    input  logic [NUM_RD-1:0]          Ren,
    input  logic [NUM_RD*ADDR_W-1:0]   Ra,
    output logic [NUM_RD*DATA_W-1:0]   Rd,
    output logic [NUM_RD-1:0]          Rbusy,
    input  logic                       Alloc_en,
    input  logic [ADDR_W-1:0]          Alloc_a
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t              state, state_d;
    logic [ADDR_W-1:0]   cnt, cnt_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]    pending, pending_d;
    logic                run;
    logic                wa0_zero, wa1_zero, alloc_zero;
    logic                we0, we1;
    logic [ADDR_W-1:0]   ra;
    logic                hit;

    assign run        = (state == RUN);
    assign ready      = run;
    assign wa0_zero   = (ZERO_REG != 0) && (Wa0 == '0);
    assign wa1_zero   = (ZERO_REG != 0) && (Wa1 == '0);
    assign alloc_zero = (ZERO_REG != 0) && (Alloc_a == '0);
    // Port 1 owns a shared address, so port 0 is suppressed on a collision.
    assign we0 = run && Wen0 && !wa0_zero && !(Wen1 && (Wa1 == Wa0));
    assign we1 = run && Wen1 && !wa1_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            cnt     <= '0;
            pending <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            pending <= pending_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            INIT: begin
                cnt_d = cnt + ADDR_W'(1);
                if (cnt == ADDR_W'(DEPTH - 1)) state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // Array has no reset; the INIT sweep clears it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) begin
                mem[cnt] <= '0;
            end else begin
                if (we0) mem[Wa0] <= Wd0;
                if (we1) mem[Wa1] <= Wd1;
            end
        end
    end

    // Set is applied after clears so an allocate beats a same-cycle writeback.
    always_comb begin
        pending_d = pending;
        if (run) begin
            if (Wen0) pending_d[Wa0] = 1'b0;
            if (Wen1) pending_d[Wa1] = 1'b0;
            if (Alloc_en && !alloc_zero) pending_d[Alloc_a] = 1'b1;
        end
        if (ZERO_REG != 0) pending_d[0] = 1'b0;
    end

    always_comb begin
        Rd    = '0;
        Rbusy = '0;
        ra    = '0;
        hit   = 1'b0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            ra  = Ra[i*ADDR_W +: ADDR_W];
            hit = 1'b0;
            if (run && Ren[i]) begin
                if ((ZERO_REG != 0) && (ra == '0)) begin
                    Rd[i*DATA_W +: DATA_W] = '0;
                end else if (Wen1 && (Wa1 == ra)) begin
                    Rd[i*DATA_W +: DATA_W] = Wd1;
                    hit = 1'b1;
                end else if (Wen0 && (Wa0 == ra)) begin
                    Rd[i*DATA_W +: DATA_W] = Wd0;
                    hit = 1'b1;
                end else begin
                    Rd[i*DATA_W +: DATA_W] = mem[ra];
                end
                Rbusy[i] = pending[ra] && !hit;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (four read ports): expectations are queued while driving
// and popped against the DUT at the falling edge of each cycle.
module tb_regfile_mp;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              ready;
    logic              wen0, wen1, alloc_en;
    logic [AW-1:0]     wa0, wa1, alloc_a;
    logic [DW-1:0]     wd0, wd1;
    logic [NR-1:0]     ren;
    logic [NR*AW-1:0]  ra;
    logic [NR*DW-1:0]  rd;
    logic [NR-1:0]     rbusy;

    typedef struct {
        string       tag;
        int          kind;   // 0 = read data, 1 = busy, 2 = ready
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .Wen0(wen0), .Wa0(wa0), .Wd0(wd0),
        .Wen1(wen1), .Wa1(wa1), .Wd1(wd1),
        .Ren(ren), .Ra(ra), .Rd(rd), .Rbusy(rbusy),
        .Alloc_en(alloc_en), .Alloc_a(alloc_a)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input int kind, input int port, input logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.kind = kind; e.port = port; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic idle();
        wen0 = 1'b0; wa0 = '0; wd0 = '0;
        wen1 = 1'b0; wa1 = '0; wd1 = '0;
        alloc_en = 1'b0; alloc_a = '0;
        ren = '0; ra = '0;
    endtask

    task automatic set_ra(input int port, input logic [AW-1:0] a);
        ra[port*AW +: AW] = a;
    endtask

    // Compare everything queued for this cycle, then advance past the next rising edge.
    task automatic step();
        exp_t        e;
        logic [31:0] obs;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                0:       obs = rd[e.port*DW +: DW];
                1:       obs = {31'b0, rbusy[e.port]};
                default: obs = {31'b0, ready};
            endcase
            n_cmp++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s port%0d: observed %h expected %h", e.tag, e.port, obs, e.exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset held: outputs quiet even with reads enabled.
        ren = 4'hF;
        for (int k = 0; k < 3; k++) begin
            push("rst_ready", 2, 0, 32'd0);
            push("rst_rd", 0, 0, 32'd0);
            push("rst_busy", 1, 0, 32'd0);
            step();
        end

        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            push("sweep1_ready", 2, 0, 32'd0);
            step();
        end
        rst = 1'b1;
        push("midrst_ready", 2, 0, 32'd0);
        step();
        rst = 1'b0;

        // Restarted sweep: ready low for exactly 32 cycles; late INIT writes/allocs ignored.
        for (int k = 0; k < 32; k++) begin
            if (k >= 20) begin
                wen0 = 1'b1; wa0 = 5'd3; wd0 = 32'hAAAA5555;
                alloc_en = 1'b1; alloc_a = 5'd4;
                ren = 4'b0001; set_ra(0, 5'd3);
                push("init_rd", 0, 0, 32'd0);
                push("init_busy", 1, 0, 32'd0);
            end
            push("sweep2_ready", 2, 0, 32'd0);
            step();
        end
        idle();
        push("ready_up", 2, 0, 32'd1);

        // Every entry reads back as zero after the sweep.
        ren = 4'hF;
        for (int b = 0; b < 32; b += 4) begin
            for (int p = 0; p < 4; p++) begin
                set_ra(p, AW'(b + p));
                push("sweep_zero", 0, p, 32'd0);
                push("sweep_busy", 1, p, 32'd0);
            end
            step();
        end

        // Write port 0 with same-cycle bypass, then readback from the array.
        idle();
        wen0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        ren = 4'b0001; set_ra(0, 5'd5);
        push("wr_bypass", 0, 0, 32'hDEADBEEF);
        step();
        idle();
        ren = 4'b0001; set_ra(0, 5'd5);
        push("wr_array", 0, 0, 32'hDEADBEEF);
        step();

        // Dual-write collision: port 1 wins both the bypass and the array.
        wen0 = 1'b1; wa0 = 5'd7; wd0 = 32'd1;
        wen1 = 1'b1; wa1 = 5'd7; wd1 = 32'd2;
        ren = 4'b0011; set_ra(0, 5'd7); set_ra(1, 5'd7);
        push("dual_bypass", 0, 0, 32'd2);
        push("dual_bypass", 0, 1, 32'd2);
        step();
        idle();
        ren = 4'b0001; set_ra(0, 5'd7);
        push("dual_array", 0, 0, 32'd2);
        step();

        // Independent writes on both ports land in their own entries.
        wen0 = 1'b1; wa0 = 5'd10; wd0 = 32'h0000_A0A0;
        wen1 = 1'b1; wa1 = 5'd11; wd1 = 32'h0000_B1B1;
        step();
        idle();
        ren = 4'b0011; set_ra(0, 5'd10); set_ra(1, 5'd11);
        push("split_p0", 0, 0, 32'h0000_A0A0);
        push("split_p1", 0, 1, 32'h0000_B1B1);
        step();

        // Zero register ignores writes and allocates.
        wen0 = 1'b1; wa0 = '0; wd0 = 32'hFFFFFFFF;
        wen1 = 1'b1; wa1 = '0; wd1 = 32'hFFFFFFFF;
        alloc_en = 1'b1; alloc_a = '0;
        ren = 4'hF; ra = '0;
        for (int p = 0; p < 4; p++) push("zero_same", 0, p, 32'd0);
        step();
        idle();
        ren = 4'hF; ra = '0;
        push("zero_after", 0, 0, 32'd0);
        push("zero_busy", 1, 0, 32'd0);
        step();

        // Entry written during INIT stayed zero; INIT allocate left it idle.
        ren = 4'b0011; set_ra(0, 5'd3); set_ra(1, 5'd4);
        push("init_wr_ignored", 0, 0, 32'd0);
        push("init_alloc_ignored", 1, 1, 32'd0);
        step();

        // Pending bit lifecycle on register 9.
        idle();
        alloc_en = 1'b1; alloc_a = 5'd9;
        ren = 4'b0001; set_ra(0, 5'd9);
        push("alloc_same_cycle", 1, 0, 32'd0);
        step();
        idle();
        ren = 4'b0001; set_ra(0, 5'd9);
        push("alloc_busy", 1, 0, 32'd1);
        step();
        ren = 4'b0000;
        push("busy_gated", 1, 0, 32'd0);
        step();
        wen1 = 1'b1; wa1 = 5'd9; wd1 = 32'h0000_1234;
        ren = 4'b0001;
        push("wb_bypass_busy", 1, 0, 32'd0);
        push("wb_bypass_rd", 0, 0, 32'h0000_1234);
        step();
        idle();
        ren = 4'b0001; set_ra(0, 5'd9);
        push("wb_cleared", 1, 0, 32'd0);
        push("wb_array", 0, 0, 32'h0000_1234);
        step();
        alloc_en = 1'b1; alloc_a = 5'd9;
        wen0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0000_0055;
        step();
        idle();
        ren = 4'b0001; set_ra(0, 5'd9);
        push("set_beats_clear", 1, 0, 32'd1);
        push("set_clear_data", 0, 0, 32'h0000_0055);
        step();

        // Per-port read enable gating.
        ren = 4'b0101;
        for (int p = 0; p < 4; p++) set_ra(p, 5'd5);
        push("ren_gate", 0, 0, 32'hDEADBEEF);
        push("ren_gate", 0, 1, 32'd0);
        push("ren_gate", 0, 2, 32'hDEADBEEF);
        push("ren_gate", 0, 3, 32'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
